// File: rtl/lcd_pkg.sv
// Shared command bytes, delay helpers and sequencer types for the 2x16 character LCD driver.
// Build option LCD_CURSOR_EN: display-on byte turns cursor and blink on.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] ENTRY    = 8'h06;
`ifdef LCD_CURSOR_EN
    localparam logic [7:0] DISP_ON  = 8'h0F;
`else
    localparam logic [7:0] DISP_ON  = 8'h0C;
`endif
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    localparam int CNT_W = 32;

    localparam logic [5:0] STEP_REFRESH = 6'd8;
`ifdef LCD_CURSOR_EN
    localparam logic [5:0] STEP_LAST    = 6'd42;
`else
    localparam logic [5:0] STEP_LAST    = 6'd41;
`endif

    // Whole clock cycles covering ns nanoseconds at clkHz, rounded up and never zero.
    function automatic logic [CNT_W-1:0] delayCycles(input longint unsigned ns,
                                                     input longint unsigned clkHz);
        longint unsigned c;
        c = (ns * clkHz + 64'd999_999_999) / 64'd1_000_000_000;
        return (c == 64'd0) ? 32'd1 : c[CNT_W-1:0];
    endfunction

    typedef enum logic [2:0] {
        POWER_WAIT, ISSUE, SEND_HIGH, NIB_GAP, SEND_LOW, POST_WAIT
    } seqState_t;

    typedef enum logic [1:0] {WR_IDLE, WR_SETUP, WR_PULSE, WR_HOLD} wrState_t;

    typedef enum logic [1:0] {DLY_40US, DLY_100US, DLY_4100US, DLY_1640US} delaySel_t;

    typedef struct packed {
        logic      rs;
        logic [7:0] value;
        logic      nibOnly;
        delaySel_t delay;
    } step_t;

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one 4-bit LCD transfer: setup, E strobe, hold, then a one-cycle done pulse.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nibble,
    output logic [3:0] sfD,
    output logic       lcdE,
    output logic       lcdRs,
    output logic       done
);

    localparam logic [CNT_W-1:0] SETUP_CYC = delayCycles(64'd40, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] PULSE_CYC = delayCycles(64'd230, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] HOLD_CYC  = delayCycles(64'd10, 64'(CLK_FREQ_HZ));

    wrState_t         state;
    logic [CNT_W-1:0] cnt;

    // Strobe FSM; RS/data only change in IDLE, so E is never high across a change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WR_IDLE;
            cnt   <= '0;
            sfD   <= 4'h0;
            lcdE  <= 1'b0;
            lcdRs <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                WR_IDLE: begin
                    if (start) begin
                        sfD   <= nibble;
                        lcdRs <= rs;
                        cnt   <= SETUP_CYC - 32'd1;
                        state <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (cnt == '0) begin
                        lcdE  <= 1'b1;
                        cnt   <= PULSE_CYC - 32'd1;
                        state <= WR_PULSE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        lcdE  <= 1'b0;
                        cnt   <= HOLD_CYC - 32'd1;
                        state <= WR_HOLD;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                WR_HOLD: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= WR_IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 2x16 driver: 32-byte shadow buffer, power-on init, then endless refresh.
// Build option LCD_CURSOR_EN: cursor/blink on and cursor parked on the host's edit cell each pass.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       writeEnable,
    input  logic [4:0] location,
    input  logic [7:0] data,
    output logic [7:0] readData,
    output logic [3:0] SF_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    localparam logic [CNT_W-1:0] POWER_CYC = delayCycles(64'd15_000_000, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] GAP_CYC   = delayCycles(64'd1_000, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] D40_CYC   = delayCycles(64'd40_000, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] D100_CYC  = delayCycles(64'd100_000, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] D4100_CYC = delayCycles(64'd4_100_000, 64'(CLK_FREQ_HZ));
    localparam logic [CNT_W-1:0] D1640_CYC = delayCycles(64'd1_640_000, 64'(CLK_FREQ_HZ));

    logic [7:0]       buffer [32];
    seqState_t        state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       step;
    logic [7:0]       curValue;
    logic             curNibOnly;
    delaySel_t        curDelay;
    step_t            stepInfo;
    logic [4:0]       cellIdx;
    logic [7:0]       cursorByte;
    logic [CNT_W-1:0] postCyc;
    logic             wrStart;
    logic             wrRs;
    logic [3:0]       wrNibble;
    logic             wrDone;

    assign readData = buffer[location];
    assign LCD_RW   = 1'b0;

    // Host write port; reset blanks every cell to a space.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                buffer[i] <= 8'h20;
            end
        end else if (writeEnable) begin
            buffer[location] <= data;
        end
    end

    // Script: steps 0-3 init nibbles, 4-7 config, 8-41 refresh (plus cursor step when enabled).
    always_comb begin
        cursorByte = {1'b1, location[4], 2'b00, location[3:0]};
        if (step >= 6'd9 && step <= 6'd24) begin
            cellIdx = 5'(step - 6'd9);
        end else if (step >= 6'd26 && step <= 6'd41) begin
            cellIdx = 5'(step - 6'd10);
        end else begin
            cellIdx = 5'd0;
        end
        case (step)
            6'd0:  stepInfo = '{1'b0, 8'h30, 1'b1, DLY_4100US};
            6'd1:  stepInfo = '{1'b0, 8'h30, 1'b1, DLY_100US};
            6'd2:  stepInfo = '{1'b0, 8'h30, 1'b1, DLY_40US};
            6'd3:  stepInfo = '{1'b0, 8'h20, 1'b1, DLY_40US};
            6'd4:  stepInfo = '{1'b0, FUNC_SET, 1'b0, DLY_40US};
            6'd5:  stepInfo = '{1'b0, ENTRY, 1'b0, DLY_40US};
            6'd6:  stepInfo = '{1'b0, DISP_ON, 1'b0, DLY_40US};
            6'd7:  stepInfo = '{1'b0, CLEAR, 1'b0, DLY_1640US};
            6'd8:  stepInfo = '{1'b0, LINE1, 1'b0, DLY_40US};
            6'd25: stepInfo = '{1'b0, LINE2, 1'b0, DLY_40US};
`ifdef LCD_CURSOR_EN
            6'd42: stepInfo = '{1'b0, cursorByte, 1'b0, DLY_40US};
`endif
            default: stepInfo = '{1'b1, buffer[cellIdx], 1'b0, DLY_40US};
        endcase
    end

    // Post-byte wait length for the byte in flight.
    always_comb begin
        case (curDelay)
            DLY_40US:   postCyc = D40_CYC;
            DLY_100US:  postCyc = D100_CYC;
            DLY_4100US: postCyc = D4100_CYC;
            DLY_1640US: postCyc = D1640_CYC;
            default:    postCyc = D40_CYC;
        endcase
    end

    // Byte sequencer; the byte is latched in ISSUE so later host writes cannot tear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= POWER_WAIT;
            cnt        <= POWER_CYC - 32'd1;
            step       <= 6'd0;
            curValue   <= 8'h00;
            curNibOnly <= 1'b0;
            curDelay   <= DLY_40US;
            wrStart    <= 1'b0;
            wrRs       <= 1'b0;
            wrNibble   <= 4'h0;
        end else begin
            wrStart <= 1'b0;
            case (state)
                POWER_WAIT: begin
                    if (cnt == '0) begin
                        step  <= 6'd0;
                        state <= ISSUE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ISSUE: begin
                    curValue   <= stepInfo.value;
                    curNibOnly <= stepInfo.nibOnly;
                    curDelay   <= stepInfo.delay;
                    wrRs       <= stepInfo.rs;
                    wrNibble   <= stepInfo.value[7:4];
                    wrStart    <= 1'b1;
                    state      <= SEND_HIGH;
                end
                SEND_HIGH: begin
                    if (wrDone) begin
                        if (curNibOnly) begin
                            cnt   <= postCyc - 32'd1;
                            state <= POST_WAIT;
                        end else begin
                            cnt   <= GAP_CYC - 32'd1;
                            state <= NIB_GAP;
                        end
                    end
                end
                NIB_GAP: begin
                    if (cnt == '0) begin
                        wrNibble <= curValue[3:0];
                        wrStart  <= 1'b1;
                        state    <= SEND_LOW;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                SEND_LOW: begin
                    if (wrDone) begin
                        cnt   <= postCyc - 32'd1;
                        state <= POST_WAIT;
                    end
                end
                POST_WAIT: begin
                    if (cnt == '0) begin
                        step  <= (step == STEP_LAST) ? STEP_REFRESH : step + 6'd1;
                        state <= ISSUE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= POWER_WAIT;
            endcase
        end
    end

    lcd_nibble_writer #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) uWriter (
        .clk    (clk),
        .rst    (rst),
        .start  (wrStart),
        .rs     (wrRs),
        .nibble (wrNibble),
        .sfD    (SF_D),
        .lcdE   (LCD_E),
        .lcdRs  (LCD_RS),
        .done   (wrDone)
    );

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: expected LCD transfers queued up front, pin monitor decodes and compares.
module tb_lcd_controller;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int POWER_CYC  = 15000;
    localparam int INIT_UNITS = 8;
`ifdef LCD_CURSOR_EN
    localparam logic [7:0] EXP_DISP = 8'h0F;
    localparam int PASS_UNITS = 35;
`else
    localparam logic [7:0] EXP_DISP = 8'h0C;
    localparam int PASS_UNITS = 34;
`endif
    localparam logic [4:0] IDLE_LOC = 5'd20;

    logic       clk = 1'b0;
    logic       rst;
    logic       writeEnable;
    logic [4:0] location;
    logic [7:0] data;
    logic [7:0] readData;
    logic [3:0] SF_D;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;

    lcd_controller #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .rst         (rst),
        .writeEnable (writeEnable),
        .location    (location),
        .data        (data),
        .readData    (readData),
        .SF_D        (SF_D),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW)
    );

    always #500 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] value;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] model [32];
    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic rs, input logic [7:0] value);
        exp_t e;
        e.rs = rs;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic pushInitNibbles();
        pushExp(1'b0, 8'h03);
        pushExp(1'b0, 8'h03);
        pushExp(1'b0, 8'h03);
        pushExp(1'b0, 8'h02);
    endtask

    task automatic pushPass();
        pushExp(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) pushExp(1'b1, model[i]);
        pushExp(1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) pushExp(1'b1, model[i]);
`ifdef LCD_CURSOR_EN
        pushExp(1'b0, 8'hC4);
`endif
    endtask

    // Pin monitor: decodes E strobes into nibbles (first four after reset) then bytes.
    logic       prevE = 1'b0;
    logic       capRs;
    logic [3:0] capNib;
    logic [3:0] hiNib;
    logic       half = 1'b0;
    logic       gotUnit;
    logic       unitRs;
    logic [7:0] unitVal;
    int nibCount = 0;
    int unitCount = 0;
    logic firstPending = 1'b0;
    int relCycle = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            prevE = 1'b0;
            nibCount = 0;
            unitCount = 0;
            half = 1'b0;
        end else begin
            if (LCD_E && !prevE) begin
                capRs = LCD_RS;
                capNib = SF_D;
                if (firstPending) begin
                    firstPending = 1'b0;
                    checks++;
                    if (cycle - relCycle < POWER_CYC) begin
                        failures++;
                        $display("FAIL first_e_delay actual=%0d cycles required>=%0d", cycle - relCycle, POWER_CYC);
                    end
                end
            end else if (!LCD_E && prevE) begin
                check("e_high_stable", 32'({LCD_RS, SF_D}), 32'({capRs, capNib}));
                gotUnit = 1'b0;
                if (nibCount < 4) begin
                    unitRs = capRs;
                    unitVal = {4'h0, capNib};
                    gotUnit = 1'b1;
                end else if (!half) begin
                    hiNib = capNib;
                    half = 1'b1;
                end else begin
                    unitRs = capRs;
                    unitVal = {hiNib, capNib};
                    half = 1'b0;
                    gotUnit = 1'b1;
                end
                nibCount++;
                if (gotUnit) begin
                    if (expQ.size() > 0) begin
                        e = expQ.pop_front();
                        check($sformatf("unit%0d_rs", unitCount), 32'(unitRs), 32'(e.rs));
                        check($sformatf("unit%0d_val", unitCount), 32'(unitVal), 32'(e.value));
                    end
                    unitCount++;
                end
            end
            prevE = LCD_E;
        end
    end

    task automatic waitUnits(input int n, input int budget, input string name);
        int k = 0;
        while (unitCount < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (unitCount < n) begin
            checks++;
            failures++;
            $display("FAIL %s timeout units=%0d required=%0d", name, unitCount, n);
        end
    endtask

    task automatic hostWrite(input logic [4:0] loc, input logic [7:0] val, input logic [7:0] oldVal);
        location = loc;
        data = val;
        writeEnable = 1'b1;
        #1;
        check($sformatf("rd_old_%0d", loc), 32'(readData), 32'(oldVal));
        @(negedge clk);
        writeEnable = 1'b0;
        check($sformatf("rd_new_%0d", loc), 32'(readData), 32'(val));
        location = IDLE_LOC;
    endtask

    task automatic checkAllSpaces(input string name);
        for (int i = 0; i < 32; i++) begin
            location = 5'(i);
            #1;
            check($sformatf("%s_cell%0d", name, i), 32'(readData), 32'h20);
        end
        location = IDLE_LOC;
    endtask

    task automatic checkPinsIdle(input string name);
        check({name, "_sfd"}, 32'(SF_D), 32'h0);
        check({name, "_e"}, 32'(LCD_E), 32'h0);
        check({name, "_rs"}, 32'(LCD_RS), 32'h0);
        check({name, "_rw"}, 32'(LCD_RW), 32'h0);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        writeEnable = 1'b0;
        location = IDLE_LOC;
        data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkPinsIdle("rst");
        checkAllSpaces("rst_buf");

        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        pushInitNibbles();
        pushExp(1'b0, 8'h28);
        pushExp(1'b0, 8'h06);
        pushExp(1'b0, EXP_DISP);
        pushExp(1'b0, 8'h01);
        pushPass();
        model[17] = 8'h41;
        pushPass();
        pushPass();
        model[5] = 8'h35;
        pushPass();

        @(negedge clk);
        relCycle = cycle;
        firstPending = 1'b1;
        rst = 1'b1;

        // Pass A: cell 17 already sent, so 0x41 first appears in pass B.
        waitUnits(INIT_UNITS + 20, 30000, "wait_passA_cell17");
        hostWrite(5'd17, 8'h41, 8'h20);

        // Pass C: write cell 5 after its high nibble is on the pins.
        k = 0;
        while (!(unitCount == INIT_UNITS + 2 * PASS_UNITS + 6 && half) && k < 10000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10000) begin
            checks++;
            failures++;
            $display("FAIL wait_passC_cell5 timeout units=%0d", unitCount);
        end
        hostWrite(5'd5, 8'h35, 8'h20);

        waitUnits(INIT_UNITS + 4 * PASS_UNITS, 10000, "wait_passD_end");
        check("queue_drained", 32'(expQ.size()), 32'd0);
        location = 5'd5;
        #1;
        check("rd_cell5_kept", 32'(readData), 32'h35);
        location = 5'd17;
        #1;
        check("rd_cell17_kept", 32'(readData), 32'h41);
        location = IDLE_LOC;

        // Abort a byte in flight with reset.
        waitUnits(INIT_UNITS + 4 * PASS_UNITS + 2, 1000, "wait_passE");
        k = 0;
        while (!LCD_E && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("e_high_before_abort", 32'(LCD_E), 32'h1);
        rst = 1'b0;
        #1;
        checkPinsIdle("abort");
        checkAllSpaces("abort_buf");
        repeat (3) @(negedge clk);
        pushInitNibbles();
        relCycle = cycle;
        firstPending = 1'b1;
        rst = 1'b1;
        waitUnits(4, 25000, "wait_reinit");
        check("reinit_queue_drained", 32'(expQ.size()), 32'd0);

        summary();
        $finish;
    end

    initial begin
        repeat (95000) @(posedge clk);
        checks++;
        failures++;
        $display("FAIL watchdog cycles=%0d", cycle);
        summary();
        $finish;
    end

endmodule
